// File: rtl/sar_pkg.sv
// Shared constants for the SAR ADC control path: FSM state codes, bit-cycle
// phase codes and default sizing reused by the CDAC and the sequencer.
package sar_pkg;

    localparam int unsigned NbitsDefault      = 8;
    localparam int unsigned SampCyclesDefault = 2;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSample  = 2'd1;
    localparam logic [1:0] StConvert = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    localparam logic PhSet = 1'b0;
    localparam logic PhCmp = 1'b1;

endpackage

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: holds the sampling switch closed, then runs a
// SET/CMP binary search over the CDAC and publishes the code with a valid pulse.
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int unsigned NBITS       = NbitsDefault,
    parameter int unsigned SAMP_CYCLES = SampCyclesDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             comp_out,
    output logic             samp,
    output logic             comp_en,
    output logic [NBITS-1:0] dac_ctrl,
    output logic [NBITS-1:0] dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int unsigned     BW  = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [NBITS-1:0] Msb = {1'b1, {(NBITS - 1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic             phase_q, phase_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             samp_q, samp_d;
    logic             comp_en_q, comp_en_d;
    logic [NBITS-1:0] dac_q, dac_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;

    logic [NBITS-1:0] onehot;
    logic [NBITS-1:0] kept;

    always_comb begin
        onehot        = '0;
        onehot[bit_q] = 1'b1;
    end

    // Trial bit survives only if the comparator says vin is at or above the trial level.
    assign kept = comp_out ? dac_q : (dac_q & ~onehot);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        samp_d       = samp_q;
        comp_en_d    = 1'b0;
        dac_d        = dac_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSample;
                    samp_d  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            StSample: begin
                if (cnt_q == 4'(SAMP_CYCLES - 1)) begin
                    state_d = StConvert;
                    samp_d  = 1'b0;
                    phase_d = PhSet;
                    bit_d   = BW'(NBITS - 1);
                    dac_d   = Msb;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StConvert: begin
                if (phase_q == PhSet) begin
                    phase_d   = PhCmp;
                    comp_en_d = 1'b1;
                end else if (bit_q == '0) begin
                    state_d      = StDone;
                    dac_d        = kept;
                    dout_d       = kept;
                    dout_valid_d = 1'b1;
                end else begin
                    phase_d = PhSet;
                    bit_d   = bit_q - BW'(1);
                    dac_d   = kept | (onehot >> 1);
                end
            end
            StDone: begin
                state_d = StIdle;
                dac_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            phase_q      <= PhSet;
            cnt_q        <= '0;
            bit_q        <= BW'(NBITS - 1);
            samp_q       <= 1'b0;
            comp_en_q    <= 1'b0;
            dac_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            samp_q       <= samp_d;
            comp_en_q    <= comp_en_d;
            dac_q        <= dac_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign samp       = samp_q;
    assign comp_en    = comp_en_q;
    assign dac_ctrl   = dac_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Self-checking bench for sar_sequencer: default 8-bit instance and a 4-bit,
// single-sample-cycle instance, both against an arithmetic binary-search model.
module tb_sar_sequencer;

    logic clk;
    logic rst;

    // Default instance (NBITS=8, SAMP_CYCLES=2)
    logic       start;
    logic [7:0] vin;
    logic       comp_out;
    logic       samp, comp_en, dout_valid, busy;
    logic [7:0] dac_ctrl, dout;

    // Corner instance (NBITS=4, SAMP_CYCLES=1)
    logic       s_start;
    logic [3:0] s_vin;
    logic       s_comp_out;
    logic       s_samp, s_comp_en, s_dout_valid, s_busy;
    logic [3:0] s_dac_ctrl, s_dout;

    int n_total;
    int n_bad;
    logic [15:0] exp_dout_main;
    logic [15:0] exp_dout_small;

    assign comp_out   = (vin >= dac_ctrl);
    assign s_comp_out = (s_vin >= s_dac_ctrl);

    sar_sequencer #(.NBITS(8), .SAMP_CYCLES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .comp_out   (comp_out),
        .samp       (samp),
        .comp_en    (comp_en),
        .dac_ctrl   (dac_ctrl),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    sar_sequencer #(.NBITS(4), .SAMP_CYCLES(1)) u_small (
        .clk        (clk),
        .rst        (rst),
        .start      (s_start),
        .comp_out   (s_comp_out),
        .samp       (s_samp),
        .comp_en    (s_comp_en),
        .dac_ctrl   (s_dac_ctrl),
        .dout       (s_dout),
        .dout_valid (s_dout_valid),
        .busy       (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Check every output of the selected instance against idle/reset values.
    task automatic check_idle(input int which, input string tag, input logic [15:0] exp_d);
        if (which == 0) begin
            check_eq({tag, ".samp"},  32'(samp),       32'd0);
            check_eq({tag, ".cmp"},   32'(comp_en),    32'd0);
            check_eq({tag, ".dac"},   32'(dac_ctrl),   32'd0);
            check_eq({tag, ".dout"},  32'(dout),       32'(exp_d));
            check_eq({tag, ".valid"}, 32'(dout_valid), 32'd0);
            check_eq({tag, ".busy"},  32'(busy),       32'd0);
        end else begin
            check_eq({tag, ".s_samp"},  32'(s_samp),       32'd0);
            check_eq({tag, ".s_cmp"},   32'(s_comp_en),    32'd0);
            check_eq({tag, ".s_dac"},   32'(s_dac_ctrl),   32'd0);
            check_eq({tag, ".s_dout"},  32'(s_dout),       32'(exp_d));
            check_eq({tag, ".s_valid"}, 32'(s_dout_valid), 32'd0);
            check_eq({tag, ".s_busy"},  32'(s_busy),       32'd0);
        end
    endtask

    // Runs one conversion from an IDLE cycle (entered just after a negedge) and
    // checks every cycle through the following IDLE cycle.
    task automatic run_conv(input int which, input logic [15:0] v, input bit hold);
        int n, s, len, k, idx;
        logic [15:0] code, t;
        logic [15:0] trials [16];
        logic [15:0] e_dac, e_dout;
        logic e_samp, e_cmp, e_valid, e_busy;
        logic o_samp, o_cmp, o_valid, o_busy;
        logic [15:0] o_dac, o_dout;

        n   = (which == 0) ? 8 : 4;
        s   = (which == 0) ? 2 : 1;
        len = s + 2 * n + 1;

        code = '0;
        for (int b = n - 1; b >= 0; b--) begin
            t = code + (16'd1 << b);
            trials[n - 1 - b] = t;
            if (v >= t) code = t;
        end

        if (which == 0) begin
            vin = v[7:0];
            start = 1'b1;
        end else begin
            s_vin = v[3:0];
            s_start = 1'b1;
        end
        @(posedge clk);

        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            if (which == 0) begin
                o_samp = samp; o_cmp = comp_en; o_valid = dout_valid; o_busy = busy;
                o_dac = 16'(dac_ctrl); o_dout = 16'(dout);
            end else begin
                o_samp = s_samp; o_cmp = s_comp_en; o_valid = s_dout_valid; o_busy = s_busy;
                o_dac = 16'(s_dac_ctrl); o_dout = 16'(s_dout);
            end

            e_samp  = (c >= 1) && (c <= s);
            e_cmp   = (c > s) && (c <= s + 2 * n) && (((c - s) % 2) == 0);
            e_valid = (c == len);
            e_busy  = (c <= len);
            if (c <= s) e_dac = '0;
            else if (c <= s + 2 * n) begin
                idx = (c - s - 1) / 2;
                e_dac = trials[idx];
            end
            else if (c == len) e_dac = code;
            else e_dac = '0;

            if (which == 0) begin
                if (c >= len) exp_dout_main = code;
                e_dout = exp_dout_main;
            end else begin
                if (c >= len) exp_dout_small = code;
                e_dout = exp_dout_small;
            end

            check_eq("samp",    32'(o_samp),  32'(e_samp));
            check_eq("comp_en", 32'(o_cmp),   32'(e_cmp));
            check_eq("dac",     32'(o_dac),   32'(e_dac));
            check_eq("dout",    32'(o_dout),  32'(e_dout));
            check_eq("valid",   32'(o_valid), 32'(e_valid));
            check_eq("busy",    32'(o_busy),  32'(e_busy));
            check_eq("overlap", 32'(o_samp & o_cmp), 32'd0);

            // Random start requests while busy must be ignored.
            k = (c <= len) ? int'($urandom_range(0, 1)) : (hold ? 1 : 0);
            if (which == 0) start = k[0];
            else s_start = k[0];
        end
    endtask

    initial begin
        logic [15:0] r;
        n_total = 0;
        n_bad   = 0;
        exp_dout_main  = '0;
        exp_dout_small = '0;
        rst = 1'b1; start = 1'b0; vin = '0; s_start = 1'b0; s_vin = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "reset", 16'd0);
        check_idle(1, "reset", 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed nominal and extremes
        run_conv(0, 16'h00A5, 1'b0);
        run_conv(0, 16'h00FF, 1'b0);
        run_conv(0, 16'h0000, 1'b0);

        // Random codes with random start chatter while busy
        for (int i = 0; i < 6; i++) begin
            r = 16'($urandom_range(0, 255));
            run_conv(0, r, 1'b0);
        end

        // start held high: back-to-back conversions every 20 cycles
        run_conv(0, 16'h005A, 1'b1);
        run_conv(0, 16'h00C3, 1'b1);
        run_conv(0, 16'h0081, 1'b0);

        // Reset in cycle 10 of a conversion
        vin = 8'h77;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) rst = 1'b1;
        end
        @(negedge clk);
        exp_dout_main  = '0;
        exp_dout_small = '0;
        check_idle(0, "midrst", 16'd0);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_idle(0, "postrst", 16'd0);
        end
        run_conv(0, 16'h003C, 1'b0);

        // Parameter corner: NBITS=4, SAMP_CYCLES=1
        run_conv(1, 16'h0009, 1'b0);
        run_conv(1, 16'h000F, 1'b0);
        run_conv(1, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom_range(0, 15));
            run_conv(1, r, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
